input_debounce: RTL and testbench
=================================

INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive clock cycles the synchronized button must remain stable before a level change is accepted (10 ms at 100 MHz); legal range 2..(2^CNT_W - 1).
REQ-002 Parameter CNT_W, default 20, is the width of the stability counter.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port Btn, input, 1 bit: raw asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 Port Btn_pulse, output, 1 bit: single-cycle, high-active pulse, one per accepted press.

Function
REQ-007 Btn SHALL pass through a two-flop synchronizer (s1 <= Btn, s2 <= s1); only s2 SHALL feed the FSM.
REQ-008 The FSM SHALL have exactly five states: IDLE, PRESS_WAIT, PULSE, HELD, RELEASE_WAIT.
REQ-009 IDLE: if s2=1, go to PRESS_WAIT and clear the counter to 0; otherwise remain.
REQ-010 PRESS_WAIT: if s2=0, return to IDLE (bounce rejected, no pulse); else if counter = DEBOUNCE_CYCLES-1, go to PULSE; else increment the counter.
REQ-011 PULSE: go unconditionally to HELD after one cycle, regardless of s2.
REQ-012 HELD: if s2=0, go to RELEASE_WAIT and clear the counter; otherwise remain indefinitely with no further pulses (no auto-repeat).
REQ-013 RELEASE_WAIT: if s2=1, return to HELD (release bounce rejected, no pulse); else if counter = DEBOUNCE_CYCLES-1, go to IDLE; else increment the counter.
REQ-014 Btn_pulse SHALL be 1 exactly when the state register equals PULSE (Moore, registered-state decode, glitch-free); it SHALL never be high for two consecutive cycles.
REQ-015 Latency: if Btn is 1 at rising edge E0 and stays 1, Btn_pulse SHALL be high for exactly the one cycle following edge E0+DEBOUNCE_CYCLES+2.
REQ-016 Any 0 on s2 during PRESS_WAIT SHALL restart qualification; the full DEBOUNCE_CYCLES stable run is required again from IDLE.
REQ-017 A new press SHALL only be accepted after a full stable release (RELEASE_WAIT completed to IDLE).
REQ-018 The counter SHALL never wrap; it is compared with DEBOUNCE_CYCLES-1 before incrementing and is only used in PRESS_WAIT and RELEASE_WAIT.

Reset
REQ-019 While RESET=1 at a rising edge: state <= IDLE, counter <= 0, s1 <= 0, s2 <= 0; Btn_pulse SHALL be 0 in the following cycle.
REQ-020 Reset asserted in any state, including PULSE and PRESS_WAIT, SHALL abort the operation; no pulse SHALL be produced for the aborted press.
REQ-021 If Btn is still held when RESET deasserts, the press SHALL be qualified as a new press and produce one pulse after the REQ-015 latency, measured from the first edge with RESET=0.

Verification (DEBOUNCE_CYCLES=4)
REQ-022 Clean press: Btn 0->1 before E0, held 20 cycles -> Btn_pulse=1 only in the cycle after E6; 0 at all other times.
REQ-023 Press bounce: Btn pattern 1,1,0,1,0 (one value per cycle), then held 1 -> no pulse during the bounce; exactly one pulse 7 edges after the final 0->1 transition.
REQ-024 Long hold plus release bounce: hold 100 cycles, then 0,1,0,1, then 0 for 10 cycles -> exactly one pulse in total.
REQ-025 Glitch: Btn high for 1-3 cycles only -> Btn_pulse stays 0.
REQ-026 Reset in PRESS_WAIT: RESET pulsed 1 cycle at E4 of a clean press with Btn then released -> Btn_pulse stays 0; state IDLE after reset.
REQ-027 Two presses separated by 10 low cycles -> exactly two single-cycle pulses.

Source files
------------

// File: rtl/input_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a five-state FSM that
// emits one single-cycle pulse per press held stable for DEBOUNCE_CYCLES.
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Btn,
    output logic Btn_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PULSE,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            s1_q    <= Btn;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is checked against its last value before incrementing, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSE: begin
                state_d = HELD;
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign Btn_pulse = (state_q == PULSE);

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: a run-length reference model predicts
// the edge after which each pulse appears, and a monitor matches observed pulses.
module tb_input_debounce;

    localparam int D = 4;

    logic CLK;
    logic RESET;
    logic Btn;
    logic Btn_pulse;

    int checks = 0;
    int errors = 0;
    int edgeNum = 0;
    int pulseCount = 0;
    int pulseQ[$];

    // Reference model state: delayed button copy, arming flag and run lengths.
    logic mS1 = 1'b0;
    logic mS2 = 1'b0;
    logic seen;
    bit   armed = 1'b1;
    bit   skip = 1'b0;
    int   run1 = 0;
    int   run0 = 0;

    input_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .Btn(Btn),
        .Btn_pulse(Btn_pulse)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // A press is accepted after D+1 consecutive high samples of the synchronized
    // button while armed; re-arming needs D+1 consecutive low samples, and the
    // sample taken on the edge right after a pulse is ignored.
    always @(posedge CLK) begin
        edgeNum++;
        if (RESET) begin
            mS1 = 1'b0;
            mS2 = 1'b0;
            armed = 1'b1;
            skip = 1'b0;
            run1 = 0;
            run0 = 0;
        end else begin
            seen = mS2;
            if (skip) begin
                skip = 1'b0;
            end else if (armed) begin
                run1 = seen ? run1 + 1 : 0;
                if (run1 == D + 1) begin
                    pulseQ.push_back(edgeNum);
                    armed = 1'b0;
                    skip = 1'b1;
                    run0 = 0;
                end
            end else begin
                run0 = seen ? 0 : run0 + 1;
                if (run0 == D + 1) begin
                    armed = 1'b1;
                    run1 = 0;
                end
            end
            mS2 = mS1;
            mS1 = Btn;
        end
    end

    // Monitor: any pulse, or any cycle where one is due, is compared with the queue head.
    always @(negedge CLK) begin
        if (edgeNum >= 1) begin
            if (Btn_pulse !== 1'b0 || (pulseQ.size() > 0 && pulseQ[0] == edgeNum)) begin
                checks++;
                if (Btn_pulse === 1'b1) pulseCount++;
                if (pulseQ.size() == 0 || pulseQ[0] != edgeNum) begin
                    errors++;
                    $display("[TB] FAIL pulse_timing: got Btn_pulse=%b after edge %0d, required 0", Btn_pulse, edgeNum);
                end else begin
                    void'(pulseQ.pop_front());
                    if (Btn_pulse !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL pulse_timing: got Btn_pulse=%b after edge %0d, required 1", Btn_pulse, edgeNum);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic b, input logic r, input int n);
        repeat (n) begin
            Btn = b;
            RESET = r;
            @(negedge CLK);
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    int startCount;
    int lvl;
    int len;

    initial begin
        Btn = 1'b0;
        RESET = 1'b1;
        applyStimulus(0, 1, 3);
        checkOutput("reset_state", int'(Btn_pulse), 0);
        applyStimulus(0, 0, 5);

        // Clean press, 20 cycles held.
        startCount = pulseCount;
        applyStimulus(1, 0, 20);
        applyStimulus(0, 0, 12);
        checkOutput("clean_press_count", pulseCount - startCount, 1);

        // Press bounce 1,1,0,1,0 then held.
        startCount = pulseCount;
        applyStimulus(1, 0, 2);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 15);
        applyStimulus(0, 0, 12);
        checkOutput("press_bounce_count", pulseCount - startCount, 1);

        // Long hold with release bounce.
        startCount = pulseCount;
        applyStimulus(1, 0, 100);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 10);
        applyStimulus(0, 0, 4);
        checkOutput("long_hold_count", pulseCount - startCount, 1);

        // Short glitches of 1..3 cycles.
        startCount = pulseCount;
        for (int g = 1; g <= 3; g++) begin
            applyStimulus(1, 0, g);
            applyStimulus(0, 0, 8);
        end
        checkOutput("glitch_count", pulseCount - startCount, 0);

        // Reset pulsed mid-qualification, button then released.
        startCount = pulseCount;
        applyStimulus(1, 0, 4);
        applyStimulus(1, 1, 1);
        checkOutput("reset_pw_output", int'(Btn_pulse), 0);
        applyStimulus(0, 0, 12);
        checkOutput("reset_pw_count", pulseCount - startCount, 0);

        // Button held through reset is qualified as a new press.
        startCount = pulseCount;
        applyStimulus(1, 1, 2);
        applyStimulus(1, 0, 12);
        applyStimulus(0, 0, 12);
        checkOutput("held_through_reset_count", pulseCount - startCount, 1);

        // Two presses separated by 10 low cycles.
        startCount = pulseCount;
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 10);
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 12);
        checkOutput("two_presses_count", pulseCount - startCount, 2);

        // Randomized bouncing segments with occasional reset.
        for (int s = 0; s < 80; s++) begin
            lvl = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(1, 5));
            if ($urandom_range(0, 19) == 0) applyStimulus(lvl[0], 1, 1);
            applyStimulus(lvl[0], 0, len);
        end
        applyStimulus(0, 0, 20);
        checkOutput("pending_pulses", pulseQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
